// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// maximum supported width and the bit-counter width function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 32;

    // Counter must index bits 0..w-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ha_cell.sv
// Combinational half-adder cell; the only arithmetic resource in the serial adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full adder (two ha_cell + OR) walked LSB-first
// over WIDTH cycles. Optional subtraction via macro SERIAL_ADDER_SUB_EN (adds port 'sub').
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic               carry_reg;
    logic               cout_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sub_bit;
    logic               last_bit;
    logic               ha0_s;
    logic               ha0_c;
    logic               fa_s;
    logic               ha1_c;
    logic               fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_bit = sub;
`else
    assign sub_bit = 1'b0;
`endif

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    ha_cell u_ha0 (
        .a (a_reg[cnt_reg]),
        .b (b_reg[cnt_reg]),
        .s (ha0_s),
        .c (ha0_c)
    );

    ha_cell u_ha1 (
        .a (ha0_s),
        .b (carry_reg),
        .s (fa_s),
        .c (ha1_c)
    );

    assign fa_c = ha0_c | ha1_c;

    // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    generate
        if (WIDTH == 1) begin : g_shift_one
            assign sum_next = fa_s;
        end else begin : g_shift_many
            assign sum_next = {fa_s, sum_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b here, seed carry with 1.
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub_bit}};
                        carry_reg <= sub_bit;
                        cnt_reg   <= '0;
                    end
                end
                ADD: begin
                    sum_reg   <= sum_next;
                    carry_reg <= fa_c;
                    if (last_bit) begin
                        cout_reg <= fa_c;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases then random operations
// compared against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, sum} is the (W+1)-bit true result of a+b or a+~b+1.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
        logic [W-1:0] ny;
        ny = ~y;
        if (s) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub requested in an add-only build");
`endif
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                          input int hold, input bit inject);
        logic [W:0] exp;
        int         lat;
        exp = model(xa, xb, xs);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        set_sub(xs);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("busy_after_accept", busy, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom);
            if (inject && lat == 2) begin
                in_valid = 1'b1;
                a = 8'h33;
                b = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", lat, W);
        chk("sum", sum, exp[W-1:0]);
        chk("cout", cout, exp[W]);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum", sum, exp[W-1:0]);
            chk("hold_cout", cout, exp[W]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_dropped", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 1);
        $display("op a=%02h b=%02h sub=%0d -> expected sum=%02h cout=%0d, got sum=%02h cout=%0d",
                 xa, xb, xs, exp[W-1:0], exp[W], sum, cout);
    endtask

    initial begin
        bit seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        set_sub(1'b0);
        repeat (2) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hAA, 8'h55, 1'b0, 0, 1'b0);
        run_op(8'h12, 8'hF0, 1'b0, 5, 1'b0);
        run_op(8'h5A, 8'hC3, 1'b0, 1, 1'b1);
        run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);

        // Abort an operation in its fourth ADD cycle.
        in_valid = 1'b1;
        a = 8'h7E;
        b = 8'h39;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("abort_no_result", seen_valid, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 0, 1'b0);
        run_op(8'h07, 8'h05, 1'b1, 0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            logic rs;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), rs, int'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
